// File: rtl/itrx_aib_phy_redn_pkg.sv
// Shared types and field helpers for the AIB redundancy controller.
// ITRX_AIB_REDN_PARITY_EN widens the config word by an odd-parity MSB.
package itrx_aib_phy_redn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRE,
      ST_SWITCH,
      ST_POST
   } redn_st_e;

   localparam int ERR_WORD   = 0;
   localparam int ERR_BUSY   = 1;
   localparam int CW_IDX_LSB = 0;

   function automatic int cw_valid_pos(input int idxw);
      return idxw;
   endfunction

   function automatic int cw_par_pos(input int idxw);
      return idxw + 1;
   endfunction

   function automatic int cw_width(input int idxw);
`ifdef ITRX_AIB_REDN_PARITY_EN
      return idxw + 2;
`else
      return idxw + 1;
`endif
   endfunction

endpackage

// File: rtl/itrx_aib_phy_redn_therm.sv
// Faulty-IO index to engage thermometer: every IO above the faulty one
// moves onto its redundant input.
module itrx_aib_phy_redn_therm #(
   parameter int NIO  = 24,
   parameter int IDXW = 5
) (
   input  logic            valid_i,
   input  logic [IDXW-1:0] idx_i,
   output logic [NIO-1:0]  therm_o
);

   always_comb begin
      therm_o = '0;
      for (int i = 0; i < NIO; i++) begin
         therm_o[i] = valid_i && (idx_i < IDXW'(i));
      end
   end

endmodule

// File: rtl/itrx_aib_phy_redn_ctrl.sv
// AIB redundancy controller: serial config load, then quiesce/switch/quiesce.
// Optional ITRX_AIB_REDN_PARITY_EN adds an odd-parity check on the config word.
module itrx_aib_phy_redn_ctrl
   import itrx_aib_phy_redn_pkg::*;
#(
   parameter int NIO    = 24,
   parameter int IDXW   = 5,
   parameter int SETTLE = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_sdi,
   input  logic           cfg_shift,
   input  logic           cfg_update,
   output logic           cfg_sdo,
   input  logic           cfg_err_clr,
   output logic [1:0]     cfg_err,
   output logic [NIO-1:0] redn_engage,
   output logic           redn_active,
   output logic           io_quiesce,
   output logic           busy
);

   localparam int W    = cw_width(IDXW);
   localparam int VPOS = cw_valid_pos(IDXW);
   localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   redn_st_e        state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [W-1:0]    sr_q, sr_d;
   logic            pend_valid_q, pend_valid_d;
   logic [IDXW-1:0] pend_idx_q, pend_idx_d;
   logic [NIO-1:0]  engage_q, engage_d;
   logic            active_q, active_d;
   logic            quiesce_q, quiesce_d;
   logic            busy_q, busy_d;
   logic [1:0]      err_q, err_d;

   logic            w_valid;
   logic [IDXW-1:0] w_idx;
   logic            range_ok;
   logic            par_ok;
   logic            word_ok;
   logic            last_cnt;
   logic [1:0]      err_set;
   logic [NIO-1:0]  therm;

   itrx_aib_phy_redn_therm #(
      .NIO  (NIO),
      .IDXW (IDXW)
   ) u_therm (
      .valid_i (pend_valid_q),
      .idx_i   (pend_idx_q),
      .therm_o (therm)
   );

   assign w_valid  = sr_q[VPOS];
   assign w_idx    = sr_q[CW_IDX_LSB +: IDXW];
   assign range_ok = !w_valid || (w_idx <= IDXW'(NIO - 2));
`ifdef ITRX_AIB_REDN_PARITY_EN
   assign par_ok   = (^sr_q) == 1'b1;
`else
   assign par_ok   = 1'b1;
`endif
   assign word_ok  = range_ok && par_ok;
   assign last_cnt = (cnt_q == CNTW'(SETTLE - 1));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sr_d         = sr_q;
      pend_valid_d = pend_valid_q;
      pend_idx_d   = pend_idx_q;
      engage_d     = engage_q;
      active_d     = active_q;
      err_set      = '0;

      if (cfg_shift) begin
         sr_d = {cfg_sdi, sr_q[W-1:1]};
      end

      // Status lags the state by one edge so the hold window fully
      // brackets the engage change on both sides.
      quiesce_d = (state_q != ST_IDLE);
      busy_d    = (state_q != ST_IDLE);

      unique case (state_q)
         ST_IDLE: begin
            if (cfg_update) begin
               if (word_ok) begin
                  pend_valid_d = w_valid;
                  pend_idx_d   = w_idx;
                  cnt_d        = '0;
                  state_d      = ST_PRE;
               end else begin
                  err_set[ERR_WORD] = 1'b1;
               end
            end
         end
         ST_PRE: begin
            if (last_cnt) begin
               state_d = ST_SWITCH;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         ST_SWITCH: begin
            engage_d = therm;
            active_d = pend_valid_q;
            cnt_d    = '0;
            state_d  = ST_POST;
         end
         ST_POST: begin
            if (last_cnt) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (cfg_update && (state_q != ST_IDLE)) begin
         err_set[ERR_BUSY] = 1'b1;
      end

      err_d = (cfg_err_clr ? 2'b00 : err_q) | err_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         sr_q         <= '0;
         pend_valid_q <= 1'b0;
         pend_idx_q   <= '0;
         engage_q     <= '0;
         active_q     <= 1'b0;
         quiesce_q    <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sr_q         <= sr_d;
         pend_valid_q <= pend_valid_d;
         pend_idx_q   <= pend_idx_d;
         engage_q     <= engage_d;
         active_q     <= active_d;
         quiesce_q    <= quiesce_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end

   assign cfg_sdo     = sr_q[0];
   assign cfg_err     = err_q;
   assign redn_engage = engage_q;
   assign redn_active = active_q;
   assign io_quiesce  = quiesce_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_itrx_aib_phy_redn_ctrl.sv
// Bench for itrx_aib_phy_redn_ctrl: directed cases plus random traffic
// against a timeline model of the apply sequence.
module tb_itrx_aib_phy_redn_ctrl;

   localparam int NIO  = 24;
   localparam int IDXW = 5;
   localparam int S    = 4;
`ifdef ITRX_AIB_REDN_PARITY_EN
   localparam int W = IDXW + 2;
`else
   localparam int W = IDXW + 1;
`endif

   logic           clk;
   logic           rst;
   logic           cfg_sdi;
   logic           cfg_shift;
   logic           cfg_update;
   logic           cfg_sdo;
   logic           cfg_err_clr;
   logic [1:0]     cfg_err;
   logic [NIO-1:0] redn_engage;
   logic           redn_active;
   logic           io_quiesce;
   logic           busy;

   itrx_aib_phy_redn_ctrl #(
      .NIO    (NIO),
      .IDXW   (IDXW),
      .SETTLE (S)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_sdi     (cfg_sdi),
      .cfg_shift   (cfg_shift),
      .cfg_update  (cfg_update),
      .cfg_sdo     (cfg_sdo),
      .cfg_err_clr (cfg_err_clr),
      .cfg_err     (cfg_err),
      .redn_engage (redn_engage),
      .redn_active (redn_active),
      .io_quiesce  (io_quiesce),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [NIO-1:0] emask(input logic v,
                                            input int idx);
      logic [NIO-1:0] m;
      m = '1;
      m = m << (idx + 1);
      return v ? m : '0;
   endfunction

   function automatic logic [W-1:0] mkword(input logic v, input int idx,
                                           input logic par_good);
      logic [W-1:0]    w;
      logic [IDXW-1:0] ix;
      ix = IDXW'(idx);
      w = '0;
      w[IDXW-1:0] = ix;
      w[IDXW] = v;
`ifdef ITRX_AIB_REDN_PARITY_EN
      w[W-1] = par_good ? ~(^{v, ix}) : (^{v, ix});
`else
      if (par_good) w[IDXW] = v;
`endif
      return w;
   endfunction

   // Model: a sequence accepted at edge T is a fixed timeline of edges.
   logic [W-1:0]   m_sr;
   logic [W-1:0]   m_pend;
   logic [NIO-1:0] m_eng;
   logic           m_act;
   logic [1:0]     m_err;
   int             m_t = -1000;

   always @(posedge clk) begin
      logic [W-1:0] word;
      logic         ok;
      logic [1:0]   set;
      int           ix;
      cyc++;
      if (rst) begin
         m_sr  = '0;
         m_eng = '0;
         m_act = 1'b0;
         m_err = '0;
         m_t   = -1000;
      end else begin
         word = m_sr;
         ix   = int'(word[IDXW-1:0]);
         set  = '0;
         ok   = !word[IDXW] || (ix <= NIO - 2);
`ifdef ITRX_AIB_REDN_PARITY_EN
         ok = ok && ($countones(word) % 2 == 1);
`endif
         if (cyc == m_t + S + 1) begin
            m_eng = emask(m_pend[IDXW], int'(m_pend[IDXW-1:0]));
            m_act = m_pend[IDXW];
         end
         if (cfg_update) begin
            if (cyc >= m_t + 2 * S + 2) begin
               if (ok) begin
                  m_t    = cyc;
                  m_pend = word;
               end else begin
                  set[0] = 1'b1;
               end
            end else begin
               set[1] = 1'b1;
            end
         end
         if (cfg_err_clr) m_err = '0;
         m_err = m_err | set;
         if (cfg_shift) m_sr = {cfg_sdi, m_sr[W-1:1]};
      end
      #1;
      chk("engage", 32'(redn_engage), 32'(m_eng));
      chk("active", 32'(redn_active), 32'(m_act));
      chk("quiesce", 32'(io_quiesce),
          32'((cyc >= m_t + 1) && (cyc <= m_t + 2 * S + 1)));
      chk("busy", 32'(busy),
          32'((cyc >= m_t + 1) && (cyc <= m_t + 2 * S + 1)));
      chk("err", 32'(cfg_err), 32'(m_err));
      chk("sdo", 32'(cfg_sdo), 32'(m_sr[0]));
   end

   task automatic cyc1(input logic sdi, input logic sh, input logic upd,
                       input logic clr, input logic r);
      @(negedge clk);
      cfg_sdi     = sdi;
      cfg_shift   = sh;
      cfg_update  = upd;
      cfg_err_clr = clr;
      rst         = r;
      @(posedge clk);
      #2;
   endtask

   task automatic shift_word(input logic [W-1:0] w);
      for (int b = 0; b < W; b++) cyc1(w[b], 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle_until(input int c);
      while (cyc < c) cyc1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   int t;

   initial begin
      cfg_sdi     = 1'b0;
      cfg_shift   = 1'b0;
      cfg_update  = 1'b0;
      cfg_err_clr = 1'b0;
      rst         = 1'b1;
      cyc1(0, 0, 0, 0, 1);
      cyc1(0, 0, 0, 0, 1);
      chk("rst_engage", 32'(redn_engage), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_quiesce", 32'(io_quiesce), 32'h0);
      chk("rst_err", 32'(cfg_err), 32'h0);
      chk("rst_sdo", 32'(cfg_sdo), 32'h0);
      chk("rst_active", 32'(redn_active), 32'h0);
      for (int i = 0; i < 6; i++) cyc1(1'(i % 2), 1, 0, 0, 0);
      idle_until(cyc + 3);
      chk("noupd_engage", 32'(redn_engage), 32'h0);

      shift_word(mkword(1, 5, 1));
      cyc1(0, 0, 1, 0, 0);
      t = cyc;
      idle_until(t + 4);
      chk("apply_pre_engage", 32'(redn_engage), 32'h0);
      chk("apply_pre_quiesce", 32'(io_quiesce), 32'h1);
      idle_until(t + 5);
      chk("apply_engage", 32'(redn_engage), 32'hFFFFC0);
      chk("apply_active", 32'(redn_active), 32'h1);
      idle_until(t + 9);
      chk("apply_q_last", 32'(io_quiesce), 32'h1);
      chk("apply_b_last", 32'(busy), 32'h1);
      idle_until(t + 10);
      chk("apply_busy_low", 32'(busy), 32'h0);
      chk("apply_q_low", 32'(io_quiesce), 32'h0);

      shift_word(mkword(1, 23, 1));
      cyc1(0, 0, 1, 0, 0);
      chk("range_err", 32'(cfg_err), 32'h1);
      idle_until(cyc + 2);
      chk("range_busy", 32'(busy), 32'h0);
      chk("range_engage", 32'(redn_engage), 32'hFFFFC0);
      cyc1(0, 0, 0, 1, 0);
      chk("range_clr", 32'(cfg_err), 32'h0);

      shift_word(mkword(1, 10, 1));
      cyc1(0, 0, 1, 0, 0);
      t = cyc;
      idle_until(t + 2);
      cyc1(1, 1, 1, 0, 0);
      chk("coll_err", 32'(cfg_err), 32'h2);
      idle_until(t + 11);
      chk("coll_engage", 32'(redn_engage), 32'hFFF800);
      cyc1(0, 0, 0, 1, 0);

      shift_word(mkword(1, 3, 1));
      cyc1(0, 0, 1, 0, 0);
      t = cyc;
      idle_until(t + 5);
      cyc1(0, 0, 0, 0, 1);
      chk("mid_rst_engage", 32'(redn_engage), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_quiesce", 32'(io_quiesce), 32'h0);

`ifdef ITRX_AIB_REDN_PARITY_EN
      shift_word(mkword(1, 5, 0));
      cyc1(0, 0, 1, 0, 0);
      chk("par_bad_err", 32'(cfg_err), 32'h1);
      idle_until(cyc + 2);
      chk("par_bad_busy", 32'(busy), 32'h0);
      cyc1(0, 0, 0, 1, 0);
      shift_word(mkword(1, 5, 1));
      cyc1(0, 0, 1, 0, 0);
      idle_until(cyc + 11);
      chk("par_good_engage", 32'(redn_engage), 32'hFFFFC0);
`endif

      for (int i = 0; i < 4000; i++) begin
         cyc1(1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 24) == 0),
              ($urandom_range(0, 399) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
